// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one access in flight, WAIT_CYCLES wait states.
// Define DMEM_ALIGN_CHK_EN to flag and suppress misaligned accesses through resp_err.
module dmem_responder #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             req_ready,
    output logic             mem_stall,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] WAIT_VAL = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic             write_reg;
    logic [AW+1:0]    addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [WIDTH-1:0] resp_rdata_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             access;
    logic             acc_write;
    logic             acc_misaligned;
    logic [AW+1:0]    acc_addr;
    logic [AW-1:0]    acc_idx;
    logic [WIDTH-1:0] acc_wdata;
    logic             unused_upper_addr;

    assign accept = (state_reg == IDLE) && req_valid;

    // With zero wait states the access fires on the accept edge, so it must read the
    // request straight from the inputs rather than from the not-yet-loaded capture registers.
    assign access    = ((state_reg == BUSY) && (cnt_reg <= 4'd1)) || (accept && (WAIT_CYCLES == 0));
    assign acc_write = (state_reg == IDLE) ? req_write : write_reg;
    assign acc_addr  = (state_reg == IDLE) ? req_addr[AW+1:0] : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
    assign acc_idx   = acc_addr[AW+1:2];

    assign unused_upper_addr = ^req_addr[WIDTH-1:AW+2];

`ifdef DMEM_ALIGN_CHK_EN
    logic resp_err_reg;

    assign acc_misaligned = |acc_addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            resp_err_reg <= 1'b0;
        else
            resp_err_reg <= access && acc_misaligned;
    end

    assign resp_err = resp_err_reg;
`else
    logic unused_byte_offset;

    assign acc_misaligned     = 1'b0;
    assign unused_byte_offset = ^acc_addr[1:0];
    assign resp_err           = 1'b0;
`endif

    // Gating with rst keeps an access that coincides with reset from touching the array.
    always_ff @(posedge clk) begin
        if (rst && access && acc_write && !acc_misaligned)
            mem[acc_idx] <= acc_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            resp_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg <= req_write;
                        addr_reg  <= req_addr[AW+1:0];
                        wdata_reg <= req_wdata;
                        cnt_reg   <= WAIT_VAL;
                        state_reg <= (WAIT_CYCLES > 0) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg <= 4'd1)
                        state_reg <= DONE;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            if (access && !acc_write)
                resp_rdata_reg <= acc_misaligned ? '0 : mem[acc_idx];
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign mem_stall  = accept || (state_reg == BUSY);
    assign resp_valid = (state_reg == DONE);
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the pipeline's MEM-stage load/store requests with a programmable number of wait states. It accepts one request at a time and holds the pipeline with `mem_stall` until the access completes. It returns read data or a write acknowledge through a single-cycle response strobe. It sits on the memory side of the EXE2MEM/MEM2WB boundary and replaces the zero-latency data array for wait-state modelling.

## Interface
Parameters:
- `WIDTH`, `` `WIDTH`` (32): data and address width.
- `DEPTH`, 256: number of words in the array; must be a power of two.
- `WAIT_CYCLES`, 2: extra cycles between accept and response; 0–15.

Ports:
- `clk`  input  1  — sole clock; all state updates on the rising edge.
- `rst`  input  1  — asynchronous, active-low reset.
- `req_valid`  input  1  — MEM stage has a load or store (`memread | memwrite`).
- `req_write`  input  1  — 1 = store, 0 = load.
- `req_addr`  input  WIDTH  — byte address (ALU result).
- `req_wdata`  input  WIDTH  — store data.
- `req_ready`  output  1  — high only in IDLE.
- `mem_stall`  output  1  — combinational; freezes PC, IF2ID, ID2EXE and EXE2MEM.
- `resp_valid`  output  1  — one-cycle completion strobe.
- `resp_rdata`  output  WIDTH  — load data, registered.
- `resp_err`  output  1  — misaligned access flag; see Configuration.

## Operation
- **Array:** `DEPTH` x `WIDTH`, word-indexed by `req_addr[log2(DEPTH)+1:2]`.
  - Upper address bits are ignored, so addresses wrap modulo `DEPTH*4`.
  - Array contents are not reset.
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid`, capture `req_write`, `req_addr` and `req_wdata` into internal registers, and load the wait counter with `WAIT_CYCLES`.
  - Next state is BUSY if `WAIT_CYCLES` > 0, otherwise DONE.
- **BUSY:**
  - While the counter is > 1, decrement it and stay in BUSY.
  - When the counter is 1, go to DONE.
  - `req_valid` is ignored.
- **Entering DONE:** on the edge into DONE, perform the access from the captured registers.
  - Write: update the array.
  - Read: load `resp_rdata` from the array.
- **DONE:**
  - `resp_valid` = 1.
  - Next state is always IDLE; no new request is accepted in this cycle.
- **`mem_stall`** = (IDLE && `req_valid`) || BUSY. It is 0 in DONE, so the pipeline advances with `resp_rdata` valid.
- **`resp_rdata`:**
  - Holds its last read value across writes and idle cycles.
  - A write response leaves it unchanged.
- **Input changes after accept:** changes on the request inputs after the accept edge have no effect; only the captured copies are used.

## Timing
- Accept edge is at the end of cycle t (IDLE with `req_valid`).
- `resp_valid` is high in cycle t+`WAIT_CYCLES`+1, for exactly one cycle.
- `mem_stall` is high in cycles t through t+`WAIT_CYCLES`, i.e. `WAIT_CYCLES`+1 stall cycles per access.
- Back-to-back requests: the next accept is possible at cycle t+`WAIT_CYCLES`+2, so sustained throughput is one access per `WAIT_CYCLES`+2 cycles.
- Reset values:
  - State IDLE, counter 0.
  - `resp_valid` 0, `resp_rdata` 0, `resp_err` 0.
  - `req_ready` 1.
  - `mem_stall` follows `req_valid`.
- Reset asserted in BUSY: the captured request is discarded and the array is not modified. After reset release, the block is in IDLE.

## Configuration
Macro `DMEM_ALIGN_CHK_EN`.
- **Defined:**
  - An accepted request with `req_addr[1:0]` != 0 takes normal latency.
  - On entering DONE: the write is suppressed, `resp_rdata` is loaded with 0, and `resp_err` = 1 for the DONE cycle only.
  - Aligned accesses keep `resp_err` = 0.
- **Undefined:**
  - `req_addr[1:0]` is ignored.
  - `resp_err` is tied to 0.
  - No check logic is generated.

## Test plan
1. **Store then load, `WAIT_CYCLES`=2.**
   - Stimulus: store 0xDEADBEEF to 0x10, accepted cycle 0.
   - Required: `mem_stall` high cycles 0–2; `resp_valid` in cycle 3; `resp_rdata` stays 0.
   - Then a load from 0x10 accepted in cycle 4 must give `resp_valid` and `resp_rdata`=0xDEADBEEF in cycle 7.
2. **`WAIT_CYCLES`=0.**
   - Stimulus: load from 0x0 after storing 0x12345678 there.
   - Required: `mem_stall` high only in the accept cycle; `resp_valid` the next cycle with 0x12345678.
3. **Wrap-around, `DEPTH`=256.**
   - Stimulus: store 0xA5A5A5A5 to 0x400, then load from 0x000.
   - Required: load returns 0xA5A5A5A5.
4. **Back-to-back.**
   - Stimulus: `req_valid` held high with loads for 12 cycles at `WAIT_CYCLES`=2.
   - Required: `resp_valid` pulses in cycles 3, 7, 11; `req_ready` low between them.
5. **Reset mid-op.**
   - Stimulus: 0x20 initially holds 0x1; a store of 0xFF to 0x20 is in BUSY when `rst` is driven low for 1 cycle.
   - Required: all outputs return to reset values immediately.
   - A subsequent load from 0x20 returns 0x1.
6. **`DMEM_ALIGN_CHK_EN` defined.**
   - Stimulus: store 0x55 to 0x13, then load from 0x10.
   - Required: the store's DONE cycle has `resp_err`=1; the load from 0x10 returns the prior contents with `resp_err`=0.
